// File: rtl/vga_sync_controller_pkg.sv
// vga_pkg: shared types and timing constants for the VGA sync controller.
//   axis_state_t   - per-axis phase (ACTIVE, FRONT, SYNC, BACK)
//   CNT_W          - width of the position counters
//   DEF_*          - default 640x480 timing
//   axis_total()   - total length of one axis (used for H_TOTAL and V_TOTAL)
//   next_phase()   - phase successor, BACK wraps to ACTIVE
package vga_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } axis_state_t;

  function automatic int unsigned axis_total(input int unsigned act_len,
                                             input int unsigned fp_len,
                                             input int unsigned sync_len,
                                             input int unsigned bp_len);
    return act_len + fp_len + sync_len + bp_len;
  endfunction

  function automatic axis_state_t next_phase(input axis_state_t s);
    case (s)
      ACTIVE:  return FRONT;
      FRONT:   return SYNC;
      SYNC:    return BACK;
      default: return ACTIVE;
    endcase
  endfunction

endpackage

// File: rtl/vga_sync_controller_if.sv
// vga_sync_controller_if: pixel-side bundle of the VGA sync controller.
//   pix_en      - pixel-rate enable into the controller
//   hsync/vsync - active-low sync pulses
//   video_on    - position is inside the visible area
//   x/y         - current pixel / line
//   frame_start - one-cycle pulse when (0,0) is presented
// Modports: master drives pix_en and observes timing; slave is the controller.
interface vga_sync_controller_if;
  import vga_pkg::*;

  logic             pix_en;
  logic             hsync;
  logic             vsync;
  logic             video_on;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             frame_start;

  modport master (
    output pix_en,
    input  hsync, vsync, video_on, x, y, frame_start
  );

  modport slave (
    input  pix_en,
    output hsync, vsync, video_on, x, y, frame_start
  );

endinterface

// File: rtl/vga_sync_controller_axis_timing.sv
// vga_pos_cmp: 10-bit position equality comparator.
//   a_i, b_i - operands; eq_o - high when equal
//
// vga_axis_timing: one timing axis (counter + four-phase FSM).
//   clk, rst_n - clock, asynchronous active-low reset
//   adv_i      - advance the position by one
//   cnt_d_o    - counter value after this edge
//   state_d_o  - phase after this edge
//   wrap_o     - this advance takes the counter from TOTAL-1 to 0
// The next-state values are exported so the parent can register its
// outputs on the same edge as this counter, with no added latency.
module vga_pos_cmp
  import vga_pkg::*;
(
  input  logic [CNT_W-1:0] a_i,
  input  logic [CNT_W-1:0] b_i,
  output logic             eq_o
);
  assign eq_o = (a_i == b_i);
endmodule

module vga_axis_timing
  import vga_pkg::*;
#(
  parameter int unsigned ACT_LEN  = DEF_H_ACTIVE,
  parameter int unsigned FP_LEN   = DEF_H_FP,
  parameter int unsigned SYNC_LEN = DEF_H_SYNC,
  parameter int unsigned BP_LEN   = DEF_H_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv_i,
  output logic [CNT_W-1:0] cnt_d_o,
  output axis_state_t      state_d_o,
  output logic             wrap_o
);

  localparam int unsigned TOTAL = axis_total(ACT_LEN, FP_LEN, SYNC_LEN, BP_LEN);

  localparam logic [CNT_W-1:0] END_ACT  = CNT_W'(ACT_LEN - 1);
  localparam logic [CNT_W-1:0] END_FP   = CNT_W'(ACT_LEN + FP_LEN - 1);
  localparam logic [CNT_W-1:0] END_SYNC = CNT_W'(ACT_LEN + FP_LEN + SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] END_BACK = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  axis_state_t      state_q, state_d;
  logic [CNT_W-1:0] bound;
  logic             at_bound;
  logic             at_end;

  // Boundary of the phase we are currently in.
  always_comb begin
    bound = END_BACK;
    case (state_q)
      ACTIVE:  bound = END_ACT;
      FRONT:   bound = END_FP;
      SYNC:    bound = END_SYNC;
      default: bound = END_BACK;
    endcase
  end

  vga_pos_cmp u_cmp_bound (
    .a_i  (cnt_q),
    .b_i  (bound),
    .eq_o (at_bound)
  );

  vga_pos_cmp u_cmp_end (
    .a_i  (cnt_q),
    .b_i  (END_BACK),
    .eq_o (at_end)
  );

  assign wrap_o = adv_i & at_end;

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (adv_i) begin
      cnt_d = at_end ? '0 : cnt_q + CNT_W'(1);
      if (at_bound) begin
        state_d = next_phase(state_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= END_BACK;
      state_q <= BACK;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign cnt_d_o   = cnt_d;
  assign state_d_o = state_d;

endmodule

// File: rtl/vga_sync_controller.sv
// vga_sync_controller: 640x480 (parameterisable) VGA timing generator.
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   vga    - slave side of vga_sync_controller_if:
//            pix_en in; hsync, vsync, video_on, x, y, frame_start out
// All outputs are registered from the axis next-state values, so x, y,
// syncs and video_on change together on the edge that moves the counters.
module vga_sync_controller
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vga_sync_controller_if.slave vga
);

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  logic [CNT_W-1:0] h_cnt_d, v_cnt_d;
  axis_state_t      h_state_d, v_state_d;
  logic             h_wrap, v_wrap;

  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             frame_start_q, frame_start_d;

  vga_axis_timing #(
    .ACT_LEN  (H_ACTIVE),
    .FP_LEN   (H_FP),
    .SYNC_LEN (H_SYNC),
    .BP_LEN   (H_BP)
  ) u_h (
    .clk       (clk),
    .rst_n     (rst_n),
    .adv_i     (vga.pix_en),
    .cnt_d_o   (h_cnt_d),
    .state_d_o (h_state_d),
    .wrap_o    (h_wrap)
  );

  vga_axis_timing #(
    .ACT_LEN  (V_ACTIVE),
    .FP_LEN   (V_FP),
    .SYNC_LEN (V_SYNC),
    .BP_LEN   (V_BP)
  ) u_v (
    .clk       (clk),
    .rst_n     (rst_n),
    .adv_i     (h_wrap),
    .cnt_d_o   (v_cnt_d),
    .state_d_o (v_state_d),
    .wrap_o    (v_wrap)
  );

  // Vertical only advances on a horizontal wrap, so a vertical wrap is
  // exactly the edge that lands on (0,0); it is zero whenever pix_en is low.
  always_comb begin
    hsync_d       = (h_state_d != SYNC);
    vsync_d       = (v_state_d != SYNC);
    video_on_d    = (h_state_d == ACTIVE) && (v_state_d == ACTIVE);
    x_d           = h_cnt_d;
    y_d           = v_cnt_d;
    frame_start_d = v_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      x_q           <= CNT_W'(H_TOTAL - 1);
      y_q           <= CNT_W'(V_TOTAL - 1);
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video_on    = video_on_q;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_controller.sv
// Directed bench for vga_sync_controller. Three instances:
//   0: default 640x480 timing
//   1: shortened horizontal (8/1/2/1), default vertical, for full-frame checks
//   2: small timing H 4/1/2/1, V 3/1/1/1
// Expected outputs come from a position-based reference (sync/active ranges
// computed from the parameters), independent of the phase FSM.
module tb_vga_sync_controller;

  logic clk;
  logic rst_n;

  vga_sync_controller_if bus0 ();
  vga_sync_controller_if bus1 ();
  vga_sync_controller_if bus2 ();

  vga_sync_controller u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (bus0)
  );

  vga_sync_controller #(
    .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (480), .V_FP (10), .V_SYNC (2), .V_BP (33)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (bus1)
  );

  vga_sync_controller #(
    .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1)
  ) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // {ha, hf, hs, hb, va, vf, vs, vb}
  int prm [3][8];

  // Reference model position
  int   mx, my;
  logic mfs;

  // Observed values
  logic [9:0] ox, oy;
  logic       ohs, ovs, ovon, ofs;

  function automatic int htot(input int w);
    return prm[w][0] + prm[w][1] + prm[w][2] + prm[w][3];
  endfunction

  function automatic int vtot(input int w);
    return prm[w][4] + prm[w][5] + prm[w][6] + prm[w][7];
  endfunction

  // {hsync, vsync, video_on} for a given position
  function automatic logic [2:0] exp_dec(input int w, input int x, input int y);
    logic hl, vl, von;
    hl  = (x >= prm[w][0] + prm[w][1]) && (x < prm[w][0] + prm[w][1] + prm[w][2]);
    vl  = (y >= prm[w][4] + prm[w][5]) && (y < prm[w][4] + prm[w][5] + prm[w][6]);
    von = (x < prm[w][0]) && (y < prm[w][4]);
    return {~hl, ~vl, von};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic get_obs(input int w);
    case (w)
      0: begin ox = bus0.x; oy = bus0.y; ohs = bus0.hsync; ovs = bus0.vsync;
               ovon = bus0.video_on; ofs = bus0.frame_start; end
      1: begin ox = bus1.x; oy = bus1.y; ohs = bus1.hsync; ovs = bus1.vsync;
               ovon = bus1.video_on; ofs = bus1.frame_start; end
      default: begin ox = bus2.x; oy = bus2.y; ohs = bus2.hsync; ovs = bus2.vsync;
               ovon = bus2.video_on; ofs = bus2.frame_start; end
    endcase
  endtask

  task automatic check_all(input int w, input string tag);
    logic [2:0] e;
    get_obs(w);
    e = exp_dec(w, mx, my);
    chk($sformatf("%s.x", tag), 32'(ox), 32'(mx));
    chk($sformatf("%s.y", tag), 32'(oy), 32'(my));
    chk($sformatf("%s.hsync", tag), 32'(ohs), 32'(e[2]));
    chk($sformatf("%s.vsync", tag), 32'(ovs), 32'(e[1]));
    chk($sformatf("%s.video_on", tag), 32'(ovon), 32'(e[0]));
    chk($sformatf("%s.frame_start", tag), 32'(ofs), 32'(mfs));
  endtask

  task automatic set_en(input int w, input logic en);
    bus0.pix_en = (w == 0) ? en : 1'b0;
    bus1.pix_en = (w == 1) ? en : 1'b0;
    bus2.pix_en = (w == 2) ? en : 1'b0;
  endtask

  task automatic model_reset(input int w);
    mx  = htot(w) - 1;
    my  = vtot(w) - 1;
    mfs = 1'b0;
  endtask

  // One clock with pix_en = en on instance w, then check against the model.
  task automatic cycle(input int w, input logic en, input string tag);
    set_en(w, en);
    @(posedge clk);
    #1;
    if (en) begin
      mfs = (mx == htot(w) - 1) && (my == vtot(w) - 1);
      if (mx == htot(w) - 1) begin
        mx = 0;
        my = (my == vtot(w) - 1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
    end else begin
      mfs = 1'b0;
    end
    check_all(w, tag);
  endtask

  // Hold reset for a few edges (pix_en high to show it is ignored), check,
  // then release on a falling edge.
  task automatic do_reset(input int w, input string tag);
    rst_n = 1'b0;
    set_en(w, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    model_reset(w);
    check_all(w, tag);
    set_en(w, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int hs_low, von_cnt, fs_cnt, vs_low, von_bad, last_fs, gap, guard;

    prm[0] = '{640, 16, 96, 48, 480, 10, 2, 33};
    prm[1] = '{8, 1, 2, 1, 480, 10, 2, 33};
    prm[2] = '{4, 1, 2, 1, 3, 1, 1, 1};

    rst_n = 1'b0;
    set_en(0, 1'b0);
    model_reset(0);

    // Reset values on the default instance
    do_reset(0, "rst");
    chk("rst.x799", 32'(ox), 32'd799);
    chk("rst.y524", 32'(oy), 32'd524);

    // One full line plus the wrap into line 1
    hs_low = 0; von_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < 801; i++) begin
      cycle(0, 1'b1, "line");
      if (i < 800) begin
        if (!ohs) hs_low++;
        if (ovon) von_cnt++;
        if (ofs) fs_cnt++;
      end
    end
    chk("line.hsync_width", 32'(hs_low), 32'd96);
    chk("line.active_px", 32'(von_cnt), 32'd640);
    chk("line.fs_count", 32'(fs_cnt), 32'd1);
    chk("line.wrap_x", 32'(ox), 32'd0);
    chk("line.wrap_y", 32'(oy), 32'd1);

    // Enable every 4th clock: hold between enables, frame_start one clk wide
    do_reset(0, "gate_rst");
    fs_cnt = 0;
    for (int i = 0; i < 3600; i++) begin
      cycle(0, ((i % 4) == 3), "gate");
      if (ofs) fs_cnt++;
    end
    chk("gate.fs_cycles", 32'(fs_cnt), 32'd1);

    // Run to (300,1), then assert reset between edges
    guard = 0;
    while (!(mx == 300 && my == 1) && guard < 2000) begin
      cycle(0, 1'b1, "seek");
      guard++;
    end
    chk("seek.reached", 32'(guard < 2000), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset(0);
    check_all(0, "async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 1'b1, "restart");
    chk("restart.fs", 32'(ofs), 32'd1);
    chk("restart.x0", 32'(ox), 32'd0);
    chk("restart.y0", 32'(oy), 32'd0);

    // Full frame with default vertical timing (12-pixel lines)
    do_reset(1, "mid_rst");
    vs_low = 0; von_bad = 0; fs_cnt = 0; last_fs = -1; gap = 0;
    for (int i = 1; i <= 6301; i++) begin
      cycle(1, 1'b1, "mid");
      if (i <= 6300 && !ovs) vs_low++;
      if (ovon && oy >= 10'd480) von_bad++;
      if (ofs) begin
        fs_cnt++;
        if (last_fs >= 0) gap = i - last_fs;
        last_fs = i;
      end
    end
    chk("mid.vsync_cycles", 32'(vs_low), 32'd24);
    chk("mid.von_blank", 32'(von_bad), 32'd0);
    chk("mid.fs_count", 32'(fs_cnt), 32'd2);
    chk("mid.fs_gap", 32'(gap), 32'd6300);

    // Small timing: three frames plus the wrap into the fourth
    do_reset(2, "small_rst");
    fs_cnt = 0; hs_low = 0; vs_low = 0;
    for (int i = 0; i < 145; i++) begin
      cycle(2, 1'b1, "small");
      if (ofs) fs_cnt++;
      if (i < 144) begin
        if (!ohs) hs_low++;
        if (!ovs) vs_low++;
      end
    end
    chk("small.fs_count", 32'(fs_cnt), 32'd4);
    chk("small.hsync_cycles", 32'(hs_low), 32'd36);
    chk("small.vsync_cycles", 32'(vs_low), 32'd24);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
